branch_checkpoint_buffer: RTL and testbench

Circular store of per-branch recovery checkpoints (branch active-list id, free-list head, full rename map, delay-slot flag), written by rename and read by the misprediction recovery logic. It drives the branch state consumed by recovery, retires checkpoints when branches resolve correctly, and reloads its valid mask and write pointer from the recovery logic on a mispredict.

---
 rtl/branch_checkpoint_buffer_if.sv | 51 +++++
 rtl/branch_checkpoint_buffer.sv | 143 ++++++++++++++
 tb/tb_branch_checkpoint_buffer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/branch_checkpoint_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_checkpoint_buffer_if
// Description : Bus between rename/recovery and the branch checkpoint buffer.
// Revision    : 1.0  initial release
// ============================================================================
interface branch_checkpoint_buffer_if #(
    parameter int BRANCH_NUM = 4,
    parameter int REG_NUM    = 32,
    parameter int PHYS_W     = 6,
    parameter int AL_W       = 6
);
    localparam int c_PTR_W = $clog2(BRANCH_NUM);

    logic                                alloc_valid;
    logic [AL_W-1:0]                     alloc_branch_id;
    logic [PHYS_W-1:0]                   alloc_free_head;
    logic [REG_NUM*PHYS_W-1:0]           alloc_map;
    logic                                alloc_ready;
    logic                                ds_valid_in;
    logic                                resolve_valid;
    logic [AL_W-1:0]                     resolve_branch_id;
    logic                                resolve_miss;
    logic [BRANCH_NUM-1:0]               recover_valid;
    logic [c_PTR_W-1:0]                  recover_write_pointer;
    logic [BRANCH_NUM-1:0]               cp_valid;
    logic [BRANCH_NUM*AL_W-1:0]          cp_branch_id;
    logic [BRANCH_NUM*PHYS_W-1:0]        cp_free_head;
    logic [BRANCH_NUM*REG_NUM*PHYS_W-1:0] cp_map;
    logic [BRANCH_NUM-1:0]               cp_ds_valid;
    logic [c_PTR_W-1:0]                  cp_write_pointer;
    logic                                await_ds;
    logic [c_PTR_W:0]                    count;

    modport master (
        output alloc_valid, alloc_branch_id, alloc_free_head, alloc_map,
        output ds_valid_in, resolve_valid, resolve_branch_id, resolve_miss,
        output recover_valid, recover_write_pointer,
        input  alloc_ready, cp_valid, cp_branch_id, cp_free_head, cp_map,
        input  cp_ds_valid, cp_write_pointer, await_ds, count
    );

    modport slave (
        input  alloc_valid, alloc_branch_id, alloc_free_head, alloc_map,
        input  ds_valid_in, resolve_valid, resolve_branch_id, resolve_miss,
        input  recover_valid, recover_write_pointer,
        output alloc_ready, cp_valid, cp_branch_id, cp_free_head, cp_map,
        output cp_ds_valid, cp_write_pointer, await_ds, count
    );
endinterface
`default_nettype wire

// File: rtl/branch_checkpoint_buffer.sv
`default_nettype none
// ============================================================================
// Module      : branch_checkpoint_buffer
// Description : Circular store of per-branch recovery checkpoints.
//               Optional macro BRANCH_CKPT_RESOLVE_FWD_EN lets an allocation
//               reuse a full slot that a correct resolve frees the same cycle.
// Revision    : 1.0  initial release
// ============================================================================
module branch_checkpoint_buffer #(
    parameter int BRANCH_NUM = 4,
    parameter int REG_NUM    = 32,
    parameter int PHYS_W     = 6,
    parameter int AL_W       = 6
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    branch_checkpoint_buffer_if.slave   bus
);
    localparam int c_PTR_W = $clog2(BRANCH_NUM);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_MAP_W = REG_NUM * PHYS_W;

    localparam logic [0:0] c_ST_IDLE     = 1'b0;
    localparam logic [0:0] c_ST_AWAIT_DS = 1'b1;

    logic [0:0]                      r_state;
    logic [BRANCH_NUM-1:0]           r_valid;
    logic [BRANCH_NUM-1:0]           r_ds;
    logic [c_PTR_W-1:0]              r_wp;
    logic [c_PTR_W-1:0]              r_last;
    logic [c_CNT_W-1:0]              r_count;
    logic [BRANCH_NUM*AL_W-1:0]      r_id;
    logic [BRANCH_NUM*PHYS_W-1:0]    r_fh;
    logic [BRANCH_NUM*c_MAP_W-1:0]   r_map;

    logic [BRANCH_NUM-1:0]           w_hit;
    logic                            w_miss;
    logic                            w_fix;
    logic                            w_slot_free;
    logic                            w_alloc_ready;
    logic                            w_alloc;
    logic [BRANCH_NUM-1:0]           w_valid_nxt;
    logic [c_CNT_W-1:0]              w_count_nxt;

    assign w_miss = bus.resolve_valid && bus.resolve_miss;
    assign w_fix  = bus.resolve_valid && !bus.resolve_miss;

    generate
        for (genvar gi = 0; gi < BRANCH_NUM; gi++) begin : g_hit
            assign w_hit[gi] = w_fix && r_valid[gi] &&
                               (r_id[gi*AL_W +: AL_W] == bus.resolve_branch_id);
        end
    endgenerate

`ifdef BRANCH_CKPT_RESOLVE_FWD_EN
    assign w_slot_free = !r_valid[r_wp] || w_hit[r_wp];
`else
    assign w_slot_free = !r_valid[r_wp];
`endif

    assign w_alloc_ready = w_slot_free && !w_miss && (r_state == c_ST_IDLE);
    assign w_alloc       = bus.alloc_valid && w_alloc_ready;

    // Resolve clears are applied before the allocation sets its bit, so a
    // forwarded reuse of the same slot ends up valid.
    always_comb begin
        w_valid_nxt = r_valid;
        if (w_miss) begin
            w_valid_nxt = bus.recover_valid;
        end else begin
            w_valid_nxt = r_valid & ~w_hit;
            if (w_alloc) begin
                w_valid_nxt[r_wp] = 1'b1;
            end
        end
    end

    always_comb begin
        w_count_nxt = '0;
        for (int i = 0; i < BRANCH_NUM; i++) begin
            w_count_nxt = w_count_nxt + c_CNT_W'(w_valid_nxt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_valid <= '0;
            r_ds    <= '0;
            r_wp    <= '0;
            r_last  <= '0;
            r_count <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            r_count <= w_count_nxt;
            if (w_miss) begin
                r_wp    <= bus.recover_write_pointer;
                r_state <= c_ST_IDLE;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (w_alloc) begin
                            r_ds[r_wp] <= 1'b0;
                            r_last     <= r_wp;
                            r_wp       <= r_wp + 1'b1;
                            r_state    <= c_ST_AWAIT_DS;
                        end
                    end
                    c_ST_AWAIT_DS: begin
                        if (bus.ds_valid_in) begin
                            r_ds[r_last] <= 1'b1;
                            r_state      <= c_ST_IDLE;
                        end else if (bus.alloc_valid) begin
                            // A non-delay-slot instruction arrived; it retries from IDLE.
                            r_state <= c_ST_IDLE;
                        end
                    end
                    default: r_state <= c_ST_IDLE;
                endcase
            end
        end
    end

    // Payload has no reset; it only ever changes on a successful allocation.
    always_ff @(posedge clk) begin
        if (!rst && w_alloc) begin
            r_id[r_wp*AL_W +: AL_W]        <= bus.alloc_branch_id;
            r_fh[r_wp*PHYS_W +: PHYS_W]    <= bus.alloc_free_head;
            r_map[r_wp*c_MAP_W +: c_MAP_W] <= bus.alloc_map;
        end
    end

    assign bus.alloc_ready      = w_alloc_ready;
    assign bus.cp_valid         = r_valid;
    assign bus.cp_branch_id     = r_id;
    assign bus.cp_free_head     = r_fh;
    assign bus.cp_map           = r_map;
    assign bus.cp_ds_valid      = r_ds;
    assign bus.cp_write_pointer = r_wp;
    assign bus.await_ds         = (r_state == c_ST_AWAIT_DS);
    assign bus.count            = r_count;
endmodule
`default_nettype wire

// File: tb/tb_branch_checkpoint_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_checkpoint_buffer
// Description : Directed and random checks of branch_checkpoint_buffer.
// Revision    : 1.0  initial release
// ============================================================================
module tb_branch_checkpoint_buffer;
    localparam int N  = 4;
    localparam int R  = 32;
    localparam int P  = 6;
    localparam int A  = 6;
    localparam int PW = 2;
    localparam int MW = R * P;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_checkpoint_buffer_if #(.BRANCH_NUM(N), .REG_NUM(R), .PHYS_W(P), .AL_W(A)) bus ();

    branch_checkpoint_buffer #(.BRANCH_NUM(N), .REG_NUM(R), .PHYS_W(P), .AL_W(A)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [N-1:0]   m_valid;
    logic [N-1:0]   m_ds;
    logic [N-1:0]   m_wr;
    logic [A-1:0]   m_id  [N];
    logic [P-1:0]   m_fh  [N];
    logic [MW-1:0]  m_map [N];
    int             m_wp;
    int             m_last;
    bit             m_await;
    bit             last_ready;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int pop;
        pop = 0;
        for (int i = 0; i < N; i++) begin
            pop += int'(m_valid[i]);
            if (m_wr[i]) begin
                check("cp_branch_id", 256'(bus.cp_branch_id[i*A +: A]), 256'(m_id[i]));
                check("cp_free_head", 256'(bus.cp_free_head[i*P +: P]), 256'(m_fh[i]));
                check("cp_map", 256'(bus.cp_map[i*MW +: MW]), 256'(m_map[i]));
            end
        end
        check("cp_valid", 256'(bus.cp_valid), 256'(m_valid));
        check("cp_ds_valid", 256'(bus.cp_ds_valid), 256'(m_ds));
        check("cp_write_pointer", 256'(bus.cp_write_pointer), 256'(m_wp));
        check("count", 256'(bus.count), 256'(pop));
        check("await_ds", 256'(bus.await_ds), 256'(m_await));
    endtask

    task automatic step(input bit rs, input bit av, input logic [A-1:0] aid,
                        input logic [P-1:0] afh, input logic [MW-1:0] amap,
                        input bit dsi, input bit rv, input logic [A-1:0] rid,
                        input bit rm, input logic [N-1:0] rvm, input logic [PW-1:0] rwp);
        bit rdy;
        bit free;
        rst = rs;
        bus.alloc_valid = av;
        bus.alloc_branch_id = aid;
        bus.alloc_free_head = afh;
        bus.alloc_map = amap;
        bus.ds_valid_in = dsi;
        bus.resolve_valid = rv;
        bus.resolve_branch_id = rid;
        bus.resolve_miss = rm;
        bus.recover_valid = rvm;
        bus.recover_write_pointer = rwp;
        #2;
        free = !m_valid[m_wp];
`ifdef BRANCH_CKPT_RESOLVE_FWD_EN
        if (rv && !rm && m_valid[m_wp] && m_id[m_wp] == rid) free = 1'b1;
`endif
        rdy = free && !(rv && rm) && !m_await;
        check("alloc_ready", 256'(bus.alloc_ready), 256'(rdy));
        last_ready = bus.alloc_ready;
        if (rs) begin
            m_valid = '0; m_ds = '0; m_wp = 0; m_last = 0; m_await = 1'b0;
        end else if (rv && rm) begin
            m_valid = rvm; m_wp = int'(rwp); m_await = 1'b0;
        end else begin
            if (rv)
                for (int i = 0; i < N; i++)
                    if (m_valid[i] && m_id[i] == rid) m_valid[i] = 1'b0;
            if (m_await) begin
                if (dsi) begin
                    m_ds[m_last] = 1'b1; m_await = 1'b0;
                end else if (av) begin
                    m_await = 1'b0;
                end
            end else if (av && rdy) begin
                m_id[m_wp] = aid; m_fh[m_wp] = afh; m_map[m_wp] = amap;
                m_valid[m_wp] = 1'b1; m_ds[m_wp] = 1'b0; m_wr[m_wp] = 1'b1;
                m_last = m_wp; m_wp = (m_wp + 1) % N; m_await = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    function automatic logic [MW-1:0] rand_map();
        logic [MW-1:0] m;
        for (int r = 0; r < R; r++) m[r*P +: P] = P'($urandom);
        return m;
    endfunction

    task automatic nop();
        step(0, 0, '0, '0, '0, 0, 0, '0, 0, '0, '0);
    endtask

    task automatic ds();
        step(0, 0, '0, '0, '0, 1, 0, '0, 0, '0, '0);
    endtask

    task automatic alloc(input logic [A-1:0] aid);
        step(0, 1, aid, P'($urandom), rand_map(), 0, 0, '0, 0, '0, '0);
    endtask

    task automatic alloc_retry(input logic [A-1:0] aid);
        for (int t = 0; t < 3; t++) begin
            alloc(aid);
            if (last_ready) break;
        end
    endtask

    initial begin
        logic [MW-1:0] map1;
        m_wr = '0; m_valid = '0; m_ds = '0; m_wp = 0; m_last = 0; m_await = 1'b0;
        bus.alloc_valid = 0; bus.alloc_branch_id = '0; bus.alloc_free_head = '0;
        bus.alloc_map = '0; bus.ds_valid_in = 0; bus.resolve_valid = 0;
        bus.resolve_branch_id = '0; bus.resolve_miss = 0; bus.recover_valid = '0;
        bus.recover_write_pointer = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_valid", 256'(bus.cp_valid), 256'(0));
        check("rst_wp", 256'(bus.cp_write_pointer), 256'(0));
        check("rst_count", 256'(bus.count), 256'(0));
        check("rst_await", 256'(bus.await_ds), 256'(0));
        check("rst_ready", 256'(bus.alloc_ready), 256'(1));
        check("rst_ds", 256'(bus.cp_ds_valid), 256'(0));

        // Basic allocation with delay slot
        map1 = rand_map();
        map1[1*P +: P] = 6'd33;
        step(0, 1, 6'd5, 6'd12, map1, 0, 0, '0, 0, '0, '0);
        ds();
        check("t1_valid0", 256'(bus.cp_valid[0]), 256'(1));
        check("t1_id0", 256'(bus.cp_branch_id[0 +: A]), 256'(5));
        check("t1_fh0", 256'(bus.cp_free_head[0 +: P]), 256'(12));
        check("t1_map_r1", 256'(bus.cp_map[1*P +: P]), 256'(33));
        check("t1_ds0", 256'(bus.cp_ds_valid[0]), 256'(1));
        check("t1_wp", 256'(bus.cp_write_pointer), 256'(1));
        check("t1_count", 256'(bus.count), 256'(1));
        check("t1_await", 256'(bus.await_ds), 256'(0));

        // Fill, wrap, full refusal, resolve and reuse of slot 0
        step(1, 0, '0, '0, '0, 0, 0, '0, 0, '0, '0);
        for (int k = 1; k <= 4; k++) alloc_retry(A'(k));
        alloc(6'd5);
        alloc(6'd5);
        check("t2_full_ready", 256'(last_ready), 256'(0));
        check("t2_count", 256'(bus.count), 256'(4));
        check("t2_wp", 256'(bus.cp_write_pointer), 256'(0));
        step(0, 1, 6'd5, 6'd9, rand_map(), 0, 1, 6'd1, 0, '0, '0);
`ifdef BRANCH_CKPT_RESOLVE_FWD_EN
        check("t5_fwd_ready", 256'(last_ready), 256'(1));
        check("t5_fwd_valid", 256'(bus.cp_valid), 256'(4'b1111));
        check("t5_fwd_id0", 256'(bus.cp_branch_id[0 +: A]), 256'(5));
`else
        check("t5_ready", 256'(last_ready), 256'(0));
        check("t2_valid", 256'(bus.cp_valid), 256'(4'b1110));
        alloc(6'd5);
        check("t2_reuse_ready", 256'(last_ready), 256'(1));
`endif
        ds();

        // Mispredict overrides a same-cycle allocation
        step(0, 1, 6'd9, 6'd1, rand_map(), 0, 1, 6'd0, 1, 4'b0011, 2'd2);
        check("t3_valid", 256'(bus.cp_valid), 256'(4'b0011));
        check("t3_wp", 256'(bus.cp_write_pointer), 256'(2));
        check("t3_await", 256'(bus.await_ds), 256'(0));
        check("t3_id2", 256'(bus.cp_branch_id[2*A +: A]), 256'(3));

        // Non-delay-slot follower is refused, then retried
        alloc(6'd7);
        alloc(6'd8);
        check("t4_refused", 256'(last_ready), 256'(0));
        check("t4_ds2", 256'(bus.cp_ds_valid[2]), 256'(0));
        alloc(6'd8);
        check("t4_retry", 256'(last_ready), 256'(1));
        ds();

        // Reset while awaiting a delay slot
        step(1, 0, '0, '0, '0, 0, 0, '0, 0, '0, '0);
        alloc(6'd1); ds(); alloc(6'd2); ds(); alloc(6'd3);
        check("t6_pre_count", 256'(bus.count), 256'(3));
        step(1, 1, 6'd4, '0, '0, 0, 0, '0, 0, '0, '0);
        check("t6_valid", 256'(bus.cp_valid), 256'(0));
        check("t6_wp", 256'(bus.cp_write_pointer), 256'(0));
        check("t6_await", 256'(bus.await_ds), 256'(0));
        check("t6_ready", 256'(bus.alloc_ready), 256'(1));

        // Random traffic against the model
        for (int c = 0; c < 2000; c++) begin
            bit rs, av, dsi, rv, rm;
            logic [A-1:0] rid;
            rs  = ($urandom_range(0, 99) < 2);
            av  = ($urandom_range(0, 99) < 60);
            dsi = ($urandom_range(0, 99) < 40);
            rv  = ($urandom_range(0, 99) < 30);
            rm  = ($urandom_range(0, 99) < 25);
            rid = ($urandom_range(0, 1) == 1) ? m_id[$urandom_range(0, N-1)] : A'($urandom_range(0, 7));
            step(rs, av, A'($urandom_range(0, 7)), P'($urandom), rand_map(), dsi, rv, rid,
                 rm, N'($urandom), PW'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
